// File: rtl/fp_normalize_round.sv
// fp_normalize_round: two-stage normalize / round / pack back end of a
// single-precision multiplier.
//   S1 aligns the 48-bit significand product and forms the unbiased exponent.
//   S2 rounds, detects overflow/underflow, and packs the IEEE-754 word.
// Each stage has a valid bit and advances only into an empty or draining
// successor, so the block holds at most two words and can accept one word per cycle.
// Build option: define FP_ROUND_NEAREST_EN for round-to-nearest-even.
// The default build truncates (rounds toward zero).
module fp_normalize_round #(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic        out_unf
);

  // Pipeline control
  logic s1_valid;
  logic s2_valid;
  logic s2_free;
  logic s1_adv;
  logic in_fire;

  // S1 payload
  logic               s1_sign;
  logic               s1_zero;
  logic signed [10:0] s1_exp;
  logic [22:0]        s1_frac;
  logic               s1_guard;
  logic               s1_sticky;

  // S1 combinational normalize results
  logic signed [10:0] n_exp;
  logic [22:0]        n_frac;
  logic               n_guard;
  logic               n_sticky;

  // S2 combinational round/pack results
  logic               round_up;
  logic [23:0]        frac_sum;
  logic signed [11:0] r_exp;
  logic [31:0]        r_data;
  logic               r_ovf;
  logic               r_unf;

  // Handshake: a stage moves when the stage after it is empty or draining this cycle
  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_ready  = !s1_valid || s1_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // S1 normalize: a product in [2,4) has its leading one at bit 47; otherwise it is at bit 46
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    n_exp    = 11'(in_exp) - 11'(EXP_BIAS) + 11'(in_mant[47]);
    n_frac   = in_mant[45:23];
    n_guard  = in_mant[22];
    n_sticky = |in_mant[21:0];
    if (in_mant[47]) begin
      n_frac   = in_mant[46:24];
      n_guard  = in_mant[23];
      n_sticky = |in_mant[22:0];
    end
  end

  // S1/S2 occupancy; reset empties the pipeline immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      if (in_ready) s1_valid <= in_valid;
      if (s2_free)  s2_valid <= s1_valid;
    end
  end

  // S1 payload capture; only loaded on a handshake
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; their contents are ignored until s1_valid is set.
    if (in_fire) begin
      s1_sign   <= in_sign;
      s1_zero   <= in_zero;
      s1_exp    <= n_exp;
      s1_frac   <= n_frac;
      s1_guard  <= n_guard;
      s1_sticky <= n_sticky;
    end
  end

`ifdef FP_ROUND_NEAREST_EN
  // Round to nearest, ties to even
  always_comb begin
    round_up = s1_guard && (s1_sticky || s1_frac[0]);
  end
`else
  // Guard and sticky bits only matter in the nearest-even build
  logic unused_round_bits;
  assign unused_round_bits = s1_guard ^ s1_sticky;

  // Truncate toward zero: never increment
  always_comb begin
    round_up = 1'b0;
  end
`endif

  // S2 round and pack; a rounding carry clears the fraction and bumps the exponent
  always_comb begin
    frac_sum = {1'b0, s1_frac} + {23'd0, round_up};
    r_exp    = {s1_exp[10], s1_exp} + {11'd0, frac_sum[23]};
    r_data   = {s1_sign, r_exp[7:0], frac_sum[22:0]};
    r_ovf    = 1'b0;
    r_unf    = 1'b0;
    if (s1_zero) begin
      r_data = {s1_sign, 31'h0};
    end else if (r_exp >= 12'sd255) begin
      r_data = {s1_sign, 8'hFF, 23'h0};
      r_ovf  = 1'b1;
    end else if (r_exp <= 12'sd0) begin
      r_data = {s1_sign, 31'h0};
      r_unf  = 1'b1;
    end
  end

  // Output register; holds its value while the downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= 32'h0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
    end else if (s1_adv) begin
      out_data <= r_data;
      out_ovf  <= r_ovf;
      out_unf  <= r_unf;
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round: directed vectors for fp_normalize_round.
// The driver pushes the expected result into a scoreboard when a word is accepted.
// An independent monitor pops and compares each delivered result.
// Build with FP_ROUND_NEAREST_EN defined to check the nearest-even variant.
module tb_fp_normalize_round;

`ifdef FP_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_unf;

  fp_normalize_round #(.EXP_BIAS(127)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        unf;
    int unsigned cyc;
    logic        lat;
  } exp_t;

  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [47:0] m;
    logic        z;
    logic [31:0] d;
    logic        ovf;
    logic        unf;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          accepted = 0;
  int          last_stall;
  int unsigned cyc = 0;
  logic        free_run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare each delivered word; check data holds steady while stalled
  exp_t        mon_e;
  logic        hold_v = 1'b0;
  logic [33:0] hold_val;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (hold_v) check("hold_stable", {out_data, out_ovf, out_unf}, hold_val);
      if (out_ready) begin
        hold_v = 1'b0;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %h with no result pending", out_data);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_ovf", out_ovf, mon_e.ovf);
          check("out_unf", out_unf, mon_e.unf);
          if (mon_e.lat) check("latency", cyc - mon_e.cyc, 2);
        end
      end else begin
        hold_v   = 1'b1;
        hold_val = {out_data, out_ovf, out_unf};
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  // Drive one word until accepted (bounded); push its expected result at the handshake
  task automatic send(input vec_t v);
    int waits = 0;
    bit done  = 1'b0;
    in_valid = 1'b1;
    in_sign  = v.s;
    in_exp   = v.e;
    in_mant  = v.m;
    in_zero  = v.z;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{v.d, v.ovf, v.unf, cyc, free_run});
        accepted++;
        done = 1'b1;
      end else if (waits >= 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready low for %0d cycles", waits);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    last_stall = waits;
    in_valid   = 1'b0;
    in_sign    = 1'($urandom);
    in_exp     = 10'($urandom);
    in_mant    = {16'($urandom), 32'($urandom)};
    in_zero    = 1'($urandom);
  endtask

  // Idle with garbage on the data inputs; nothing may be accepted
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_sign  = 1'($urandom);
      in_exp   = 10'($urandom);
      in_mant  = {16'($urandom), 32'($urandom)};
      in_zero  = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for the scoreboard to empty
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 10'd0;
    in_mant   = 48'h0;
    in_zero   = 1'b0;
    out_ready = 1'b1;

    // Directed vectors: sign, exp sum, product, zero, expected word, ovf, unf
    vecs.push_back('{1'b0, 10'd254, 48'h4000_0000_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 10'd254, 48'h9000_0000_0000, 1'b0, 32'h4010_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 10'd254, 48'h4000_00C0_0000, 1'b0,
                     RNE ? 32'h3F80_0002 : 32'h3F80_0001, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 10'd254, 48'h4000_0040_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 10'd400, 48'h4000_0000_0000, 1'b0, 32'h7F80_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 10'd100, 48'h4000_0000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 10'd254, 48'h4000_0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 10'd400, 48'h4000_0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 10'd382, 48'h4000_0000_0000, 1'b0, 32'h7F80_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 10'd381, 48'h4000_0000_0000, 1'b0, 32'h7F00_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 10'd128, 48'h4000_0000_0000, 1'b0, 32'h0080_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 10'd254, 48'h7FFF_FFC0_0000, 1'b0,
                     RNE ? 32'h4000_0000 : 32'h3FFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 10'd381, 48'h7FFF_FFC0_0000, 1'b0,
                     RNE ? 32'hFF80_0000 : 32'hFF7F_FFFF, RNE, 1'b0});
    vecs.push_back('{1'b0, 10'd254, 48'h8000_0080_0001, 1'b0,
                     RNE ? 32'h4000_0001 : 32'h4000_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 10'd254, 48'h4000_0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 1'b0});

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_unf", out_unf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full throughput: all vectors back to back, no bubbles, latency 2
    free_run = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i]);
      check("no_bubble", last_stall, 0);
    end
    idle(5);
    drain();

    // Backpressure: three words with out_ready low for five cycles
    free_run  = 1'b0;
    out_ready = 1'b0;
    begin
      int base;
      base = accepted;
      fork
        begin
          send(vecs[0]);
          send(vecs[1]);
          send(vecs[2]);
        end
        begin
          repeat (5) @(posedge clk);
          #1;
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
          check("bp_accepted", accepted - base, 2);
          out_ready = 1'b1;
        end
      join
    end
    drain();
    idle(3);

    // Reset mid-flight with two words held
    out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[4]);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_data", out_data, 32'h0);
    check("mid_rst_flags", {out_ovf, out_unf}, 2'b00);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    free_run  = 1'b1;
    send(vecs[5]);
    check("post_rst_accept", last_stall, 0);
    drain();
    idle(6);
    check("post_rst_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

Interface
REQ-001 SHALL have parameter EXP_BIAS, default 127, the single-precision exponent bias subtracted from the exponent sum.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  in  1  the upstream product word is valid.
REQ-005 SHALL have port in_ready  out  1  the block accepts the word this cycle.
REQ-006 SHALL have port in_sign  in  1  product sign (XOR of operand signs).
REQ-007 SHALL have port in_exp  in  10  unsigned sum of the two biased operand exponents, range 0..510.
REQ-008 SHALL have port in_mant  in  48  the 24x24 significand product from the 48-bit adder tree, hidden bits included.
REQ-009 SHALL have port in_zero  in  1  at least one operand is zero.
REQ-010 SHALL have port out_valid  out  1  result is valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts the result.
REQ-012 SHALL have port out_data  out  32  IEEE-754 single-precision result.
REQ-013 SHALL have port out_ovf  out  1  overflow flag, qualified by out_valid.
REQ-014 SHALL have port out_unf  out  1  underflow flag, qualified by out_valid.

Function
REQ-015 SHALL be a two-stage pipeline (S1 normalize, S2 round/pack) with latency 2 cycles from input handshake to out_valid when out_ready is held high.
REQ-016 SHALL at S1 use a signed 11-bit exponent: e = in_exp - EXP_BIAS + in_mant[47].
REQ-017 SHALL at S1 take the fraction from in_mant[46:24], guard = in_mant[23] and sticky = OR(in_mant[22:0]) when in_mant[47]=1; otherwise fraction in_mant[45:23], guard in_mant[22], sticky OR(in_mant[21:0]).
REQ-018 SHALL at S2 increment the fraction when the round condition (REQ-035) holds; on fraction carry-out, fraction = 0 and e = e + 1.
REQ-019 SHALL, when e >= 255 after rounding, output {sign, 8'hFF, 23'h0} with out_ovf = 1.
REQ-020 SHALL, when e <= 0 after rounding, output {sign, 31'h0} with out_unf = 1 (flush to zero, no subnormals).
REQ-021 SHALL, when in_zero = 1, output {sign, 31'h0} with both flags 0; in_zero overrides REQ-019 and REQ-020.
REQ-022 SHALL advance each stage only when its successor is empty or is being consumed in the same cycle; in_ready = !S1_valid || S1 advances (combinational, no bubble at full throughput).
REQ-023 SHALL hold out_data, out_ovf and out_unf stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL sustain one result per cycle, preserve order, and never drop or duplicate a word.
REQ-025 SHALL ignore in_sign, in_exp, in_mant and in_zero in any cycle without a handshake.
REQ-026 SHALL hold at most 2 words in flight; in_ready = 0 exactly when both stages are full and out_ready = 0.

Reset
REQ-027 SHALL on rst_n low immediately clear both stage valid bits, giving out_valid = 0 and in_ready = 1.
REQ-028 SHALL on reset drive out_data = 32'h0, out_ovf = 0 and out_unf = 0.
REQ-029 SHALL discard any in-flight words when reset is asserted mid-operation; no result from before reset appears afterwards.
REQ-030 SHALL accept a handshake on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL compile round-to-nearest-even when macro FP_ROUND_NEAREST_EN is defined.
REQ-032 SHALL use the round condition guard && (sticky || fraction LSB) when FP_ROUND_NEAREST_EN is defined.
REQ-033 SHALL truncate (round toward zero, never increment) when FP_ROUND_NEAREST_EN is not defined.
REQ-034 SHALL keep latency and handshake identical in both builds.
REQ-035 SHALL define the round condition of REQ-018 as REQ-032 or REQ-033 according to the build.

Verification
REQ-036 SHALL test 1.0x1.0: in_exp=254, in_mant=48'h4000_0000_0000 -> out_data=32'h3F80_0000 two cycles later, flags 0.
REQ-037 SHALL test 1.5x1.5: in_exp=254, in_mant=48'h9000_0000_0000 -> 32'h4010_0000.
REQ-038 SHALL test rounding: in_exp=254, in_mant=48'h4000_00C0_0000 -> 32'h3F80_0002 with the macro, 32'h3F80_0001 without; in_mant=48'h4000_0040_0000 -> 32'h3F80_0000 in both builds.
REQ-039 SHALL test overflow and underflow: in_exp=400 -> 32'h7F80_0000 with out_ovf=1; in_exp=100, sign=1 -> 32'h8000_0000 with out_unf=1; in_zero=1 -> signed zero, flags 0.
REQ-040 SHALL test backpressure: 3 back-to-back inputs with out_ready=0 for 5 cycles -> 2 accepted, then in_ready=0, then all 3 results delivered in order with stable data.
REQ-041 SHALL test reset mid-flight: rst_n pulsed low with 2 words in flight -> out_valid=0 immediately, no stale result after release.
